// File: rtl/shift_add_mult_pkg.sv
// Shared constants and state encoding for the iterative shift-add multiplier.
package shift_add_mult_pkg;
  localparam int WORD     = 32;
  localparam int MUL_ITER = 32;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;
endpackage

// File: rtl/shift_add_mult_add.sv
// 32-bit combinational ripple-carry adder; the carry chain sets the minimum clock period.
module add
  import shift_add_mult_pkg::*;
(
  input  logic [WORD-1:0] i_x,
  input  logic [WORD-1:0] i_y,
  input  logic            i_cin,
  output logic [WORD-1:0] o_sum,
  output logic            o_cout
);
  logic [WORD:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar gi = 0; gi < WORD; gi++) begin : g_fa
    assign o_sum[gi]  = i_x[gi] ^ i_y[gi] ^ w_c[gi];
    assign w_c[gi+1]  = (i_x[gi] & i_y[gi]) | (w_c[gi] & (i_x[gi] ^ i_y[gi]));
  end

  assign o_cout = w_c[WORD];
endmodule

// File: rtl/shift_add_mult.sv
// Iterative 32x32 unsigned multiplier: one add-and-shift per cycle, product after 32 cycles.
// start is honoured only in IDLE or DONE; product holds from done until the next accepted start.
module shift_add_mult
  import shift_add_mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD-1:0]   a,
  input  logic [WORD-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*WORD-1:0] product
);
  mul_state_t      r_state;
  mul_state_t      w_next_state;
  logic [WORD-1:0] r_mcand;
  logic [WORD-1:0] r_hi;
  logic [WORD-1:0] r_lo;
  logic [4:0]      r_cnt;
  logic            w_load;
  logic            w_iter;
  logic [WORD-1:0] w_y;
  logic [WORD-1:0] w_sum;
  logic            w_cout;

  assign w_y = r_lo[0] ? r_mcand : '0;

  add u_add (
    .i_x    (r_hi),
    .i_y    (w_y),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_iter       = 1'b0;
    case (r_state)
      MUL_IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_next_state = MUL_RUN;
        end
      end
      MUL_RUN: begin
        w_iter = 1'b1;
        if (r_cnt == 5'(MUL_ITER - 1)) w_next_state = MUL_DONE;
      end
      MUL_DONE: begin
        if (start) begin
          w_load       = 1'b1;
          w_next_state = MUL_RUN;
        end else begin
          w_next_state = MUL_IDLE;
        end
      end
      default: w_next_state = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MUL_IDLE;
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_mcand <= a;
        r_hi    <= '0;
        r_lo    <= b;
        r_cnt   <= '0;
      end else if (w_iter) begin
        // Carry-out becomes the new MSB of the 65-bit right shift.
        {r_hi, r_lo} <= {w_cout, w_sum, r_lo[WORD-1:1]};
        r_cnt        <= r_cnt + 5'd1;
      end
    end
  end

  assign busy    = (r_state == MUL_RUN);
  assign done    = (r_state == MUL_DONE);
  assign product = {r_hi, r_lo};
endmodule

// File: tb/tb_shift_add_mult.sv
// Directed-vector bench for shift_add_mult: latency, handshake, extremes, back-to-back and reset.
module tb_shift_add_mult;
  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int n_checks;
  int n_pass;

  shift_add_mult dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called on the negedge right after the accepting edge; returns on the negedge where done is seen.
  task automatic wait_done(output int nbusy, output int lat, output bit got);
    nbusy = 0;
    lat   = 0;
    got   = 1'b0;
    for (int i = 0; i < 45 && !got; i++) begin
      if (done) begin
        got = 1'b1;
      end else begin
        if (busy) nbusy++;
        lat++;
        @(negedge clk);
      end
    end
  endtask

  task automatic issue_start(input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic run_mult(input string name, input logic [31:0] av, input logic [31:0] bv,
                          input logic [63:0] exp);
    int nbusy, lat;
    bit got;
    issue_start(av, bv);
    wait_done(nbusy, lat, got);
    n_checks++;
    if (got !== 1'b1) $display("FAIL %s_done_seen got=%0b want=1", name, got);
    else n_pass++;
    n_checks++;
    if (lat !== 32) $display("FAIL %s_latency got=%0d want=32", name, lat);
    else n_pass++;
    n_checks++;
    if (nbusy !== 32) $display("FAIL %s_busy_cycles got=%0d want=32", name, nbusy);
    else n_pass++;
    n_checks++;
    if (product !== exp) $display("FAIL %s_product got=%h want=%h", name, product, exp);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL %s_busy_with_done got=%0b want=0", name, busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) $display("FAIL reset_flags got=%b want=00", {busy, done});
    else n_pass++;
    n_checks++;
    if (product !== 64'd0) $display("FAIL reset_product got=%h want=0", product);
    else n_pass++;
  endtask

  task automatic test_basic();
    run_mult("basic", 32'd3, 32'd5, 64'd15);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) $display("FAIL basic_done_pulse got=%0b want=0", done);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (product !== 64'd15) $display("FAIL basic_hold got=%h want=f", product);
    else n_pass++;
  endtask

  task automatic test_extremes();
    run_mult("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_mult("carry", 32'h8000_0000, 32'd2, 64'h1_0000_0000);
    run_mult("mixed", 32'hDEAD_BEEF, 32'h0000_0010, 64'h0000_000D_EADB_EEF0);
  endtask

  task automatic test_zero();
    run_mult("zero_a", 32'd0, 32'h1234, 64'd0);
    run_mult("zero_b", 32'h1234, 32'd0, 64'd0);
  endtask

  task automatic test_start_while_busy();
    int ndone;
    issue_start(32'd100, 32'd200);
    repeat (9) @(negedge clk);
    start = 1'b1;
    a     = 32'd7;
    b     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        ndone++;
        n_checks++;
        if (product !== 64'd20000) $display("FAIL busy_start_product got=%h want=%h", product, 64'd20000);
        else n_pass++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (ndone !== 1) $display("FAIL busy_start_done_count got=%0d want=1", ndone);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int nbusy, lat;
    bit got;
    issue_start(32'd2, 32'd3);
    wait_done(nbusy, lat, got);
    n_checks++;
    if (!(got && product === 64'd6)) $display("FAIL b2b_first got=%h want=6", product);
    else n_pass++;
    start = 1'b1;
    a     = 32'd4;
    b     = 32'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(nbusy, lat, got);
    n_checks++;
    if (nbusy !== 32) $display("FAIL b2b_busy_cycles got=%0d want=32", nbusy);
    else n_pass++;
    n_checks++;
    if (!(got && product === 64'd20)) $display("FAIL b2b_second got=%h want=14", product);
    else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    issue_start(32'h1234_5678, 32'h9ABC_DEF0);
    repeat (15) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL midrst_running got=%0b want=1", busy);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({busy, done} !== 2'b00) $display("FAIL midrst_flags got=%b want=00", {busy, done});
    else n_pass++;
    n_checks++;
    if (product !== 64'd0) $display("FAIL midrst_product got=%h want=0", product);
    else n_pass++;
    rst   = 1'b1;
    start = 1'b1;
    a     = 32'd11;
    b     = 32'd11;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, product} !== 66'd0) $display("FAIL rst_start_same_edge busy=%0b done=%0b product=%h want=0",
                                                  busy, done, product);
    else n_pass++;
    run_mult("after_rst", 32'd9, 32'd9, 64'd81);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_basic();
    test_extremes();
    test_zero();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
